// File: rtl/spi_master.sv
// SPI mode-0 master: one MSB-first frame per start, active-low SSEL with
// setup/hold/gap spacing, response captured from a synchronized MISO.
module spi_master #(
    parameter int FRAME_BITS = 40,
    parameter int CLK_DIV    = 8,
    parameter int CS_SETUP   = 8,
    parameter int CS_HOLD    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  SCK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  SSEL
);
    localparam int DIV_MAX = (CLK_DIV > CS_SETUP) ?
                             ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                             ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CW = $clog2(DIV_MAX + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [BW-1:0] BITS_ALL   = BW'(FRAME_BITS);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bitcnt;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] rx_sr;
    logic [FRAME_BITS-1:0] tx_shl;
    logic [1:0]            miso_q;
    logic                  miso_s;

    assign miso_s = miso_q[1];
    assign tx_shl = tx_sr << 1;

    always_ff @(posedge clk) begin
        // MISO is asynchronous to clk; two flops before it is ever used
        miso_q <= {miso_q[0], MISO};
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            SCK     <= 1'b0;
            MOSI    <= 1'b0;
            SSEL    <= 1'b1;
        end else begin
            done <= 1'b0;
            cnt  <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        tx_sr  <= tx_data;
                        bitcnt <= '0;
                        MOSI   <= tx_data[FRAME_BITS-1];
                        SSEL   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        SCK   <= 1'b1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (cnt == '0)
                        rx_sr <= (rx_sr << 1) | FRAME_BITS'(miso_s);
                    // next bit goes out with the falling edge so it is stable for a full low phase
                    if (cnt == DIV_LAST) begin
                        cnt    <= '0;
                        SCK    <= 1'b0;
                        bitcnt <= bitcnt + 1'b1;
                        tx_sr  <= tx_shl;
                        MOSI   <= tx_shl[FRAME_BITS-1];
                        state  <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (bitcnt == BITS_ALL) begin
                            state <= HOLD;
                        end else begin
                            SCK   <= 1'b1;
                            state <= HIGH;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt     <= '0;
                        SSEL    <= 1'b1;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // keeps SSEL high long enough for the slave to see a fresh falling edge
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: an 8-bit and a 40-bit instance, each
// talking to an oversampling slave model (the 40-bit one also in loopback).
module tb_spi_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start8, start40, loop40;
    logic [7:0]  tx8, rx8;
    logic        busy8, done8, sck8, mosi8, ssel8;
    logic [39:0] tx40, rx40;
    logic        busy40, done40, sck40, mosi40, ssel40, miso40;
    logic [1:0]  smiso, sck_v, ssel_v, mosi_v;
    logic [1:0][39:0] sword;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master #(.FRAME_BITS(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .tx_data(tx8), .rx_data(rx8),
        .busy(busy8), .done(done8), .SCK(sck8), .MOSI(mosi8), .MISO(smiso[0]), .SSEL(ssel8));

    assign miso40 = loop40 ? mosi40 : smiso[1];
    spi_master #(.FRAME_BITS(40)) u40 (
        .clk(clk), .rst(rst), .start(start40), .tx_data(tx40), .rx_data(rx40),
        .busy(busy40), .done(done40), .SCK(sck40), .MOSI(mosi40), .MISO(miso40), .SSEL(ssel40));

    // Oversampling slave: 3-flop view of SCK/SSEL/MOSI, loads word on SSEL fall,
    // samples MOSI on SCK rise, shifts MISO on SCK fall. Word is left-justified.
    assign sck_v  = {sck40, sck8};
    assign ssel_v = {ssel40, ssel8};
    assign mosi_v = {mosi40, mosi8};
    for (genvar g = 0; g < 2; g++) begin : g_slv
        logic [2:0]  sck_q = '0, ssel_q = '1, mosi_q = '0;
        logic [39:0] sreg = '0, srx = '0;
        always @(posedge clk) begin
            sck_q  <= {sck_q[1:0], sck_v[g]};
            ssel_q <= {ssel_q[1:0], ssel_v[g]};
            mosi_q <= {mosi_q[1:0], mosi_v[g]};
            if (ssel_q[2] && !ssel_q[1]) begin
                sreg <= sword[g];
            end else if (!ssel_q[1]) begin
                if (sck_q[1] && !sck_q[2]) srx  <= {srx[38:0], mosi_q[1]};
                if (!sck_q[1] && sck_q[2]) sreg <= sreg << 1;
            end
        end
        assign smiso[g] = sreg[39];
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string msg);
        total++;
        bad++;
        $display("FAIL %s", msg);
    endtask

    // scoreboard queues
    logic [7:0]  exp8[$];
    logic [39:0] exp40[$];
    bit          bits8[$], bits40[$];
    int done8_n = 0, done40_n = 0, rise8 = 0, rise40 = 0, t_done8 = 0;
    logic sck8_d = 1'b0, sck40_d = 1'b0;

    always @(negedge clk) begin
        if (done8) begin
            done8_n++;
            t_done8 = cyc + 1;
            if (exp8.size() == 0) fail("done8_unexpected: got done=1 with no frame pending");
            else check("rx8", {32'h0, rx8}, {32'h0, exp8.pop_front()});
        end
        if (sck8 && !sck8_d) begin
            rise8++;
            if (bits8.size() == 0) fail("mosi8_extra: got SCK rise with no bit pending");
            else check("mosi8_bit", {39'h0, mosi8}, {39'h0, bits8.pop_front()});
        end
        sck8_d = sck8;
        if (done40) begin
            done40_n++;
            if (exp40.size() == 0) fail("done40_unexpected: got done=1 with no frame pending");
            else check("rx40", rx40, exp40.pop_front());
        end
        if (sck40 && !sck40_d) begin
            rise40++;
            check("ssel40_at_rise", {39'h0, ssel40}, 40'h0);
            if (bits40.size() == 0) fail("mosi40_extra: got SCK rise with no bit pending");
            else check("mosi40_bit", {39'h0, mosi40}, {39'h0, bits40.pop_front()});
        end
        sck40_d = sck40;
    end

    // Called at a negedge with the DUT idle; returns k = index of the accepting edge.
    task automatic frame8(input logic [7:0] tx, input logic [7:0] sw, output int k);
        sword[0] = {sw, 32'h0};
        for (int i = 7; i >= 0; i--) bits8.push_back(tx[i]);
        exp8.push_back(sw);
        tx8 = tx;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        k = cyc;
    endtask

    task automatic frame40(input logic [39:0] tx, input logic [39:0] sw, input logic [39:0] er);
        sword[1] = sw;
        for (int i = 39; i >= 0; i--) bits40.push_back(tx[i]);
        exp40.push_back(er);
        tx40 = tx;
        start40 = 1'b1;
        @(negedge clk);
        start40 = 1'b0;
    endtask

    // Returns the index of the first cycle with busy low.
    task automatic wait_idle(input bit which, output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((which ? busy40 : busy8) && n < 2000);
        if (which ? busy40 : busy8) fail("wait_idle: busy still 1 after 2000 cycles, required 0");
        t = cyc + 1;
    endtask

    task automatic pulse8(input int t);
        while (cyc + 1 < t) @(negedge clk);
        tx8 = 8'hFF;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    int k, t, d0, r0, dn;
    initial begin
        rst = 1'b1; start8 = 1'b0; start40 = 1'b0; loop40 = 1'b0;
        tx8 = '0; tx40 = '0; sword = '0;
        repeat (3) @(negedge clk);
        check("rst_sck",  {39'h0, sck8},  40'h0);
        check("rst_mosi", {39'h0, mosi8}, 40'h0);
        check("rst_ssel", {39'h0, ssel8}, 40'h1);
        check("rst_busy", {39'h0, busy8}, 40'h0);
        check("rst_done", {39'h0, done8}, 40'h0);
        check("rst_rx",   {32'h0, rx8},   40'h0);
        check("rst_ssel40", {39'h0, ssel40}, 40'h1);
        rst = 1'b0;
        @(negedge clk);

        // basic frame and timeline
        frame8(8'hA5, 8'h3C, k);
        check("a_ssel_low", {39'h0, ssel8}, 40'h0);
        check("a_busy_high", {39'h0, busy8}, 40'h1);
        wait_idle(1'b0, t);
        check("a_done_cycle", 40'(t_done8 - k), 40'd145);
        check("a_busy_fall", 40'(t - k), 40'd153);
        check("a_slave_rx", {32'h0, g_slv[0].srx[7:0]}, 40'hA5);
        check("a_idle_ssel", {39'h0, ssel8}, 40'h1);

        // back-to-back start in the first busy-low cycle, all-zeros then all-ones
        frame8(8'h00, 8'h00, k);
        check("b_ssel_next", {39'h0, ssel8}, 40'h0);
        wait_idle(1'b0, t);
        frame8(8'hFF, 8'hFF, k);
        wait_idle(1'b0, t);

        // starts during SETUP, HIGH and GAP must be dropped
        d0 = done8_n; r0 = rise8;
        frame8(8'h5A, 8'hC3, k);
        pulse8(k + 3);
        pulse8(k + 12);
        pulse8(k + 147);
        wait_idle(1'b0, t);
        check("d_busy_fall", 40'(t - k), 40'd153);
        check("d_done_count", 40'(done8_n - d0), 40'd1);
        check("d_rises", 40'(rise8 - r0), 40'd8);
        @(negedge clk);
        check("d_no_requeue_ssel", {39'h0, ssel8}, 40'h1);
        check("d_no_requeue_busy", {39'h0, busy8}, 40'h0);

        // reset in the middle of bit 3
        r0 = rise8;
        frame8(8'h33, 8'h99, k);
        while (cyc + 1 < k + 60) @(negedge clk);
        check("e_rises_before_rst", 40'(rise8 - r0), 40'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("e_ssel", {39'h0, ssel8}, 40'h1);
        check("e_sck",  {39'h0, sck8},  40'h0);
        check("e_busy", {39'h0, busy8}, 40'h0);
        check("e_rx",   {32'h0, rx8},   40'h0);
        check("e_done", {39'h0, done8}, 40'h0);
        exp8.delete();
        bits8.delete();
        dn = done8_n;
        repeat (200) @(negedge clk);
        check("e_no_done", 40'(done8_n - dn), 40'd0);
        frame8(8'hFF, 8'h81, k);
        wait_idle(1'b0, t);
        check("f_slave_rx", {32'h0, g_slv[0].srx[7:0]}, 40'hFF);
        check("q8_drained", 40'(exp8.size()), 40'd0);

        // 40-bit loopback
        loop40 = 1'b1;
        r0 = rise40;
        frame40(40'h12_3456_789A, 40'h0, 40'h12_3456_789A);
        wait_idle(1'b1, t);
        check("lb_rises", 40'(rise40 - r0), 40'd40);
        loop40 = 1'b0;

        // 40-bit against the oversampling slave
        @(negedge clk);
        frame40(40'hDE_ADBE_EF01, 40'h01_2345_6789, 40'h01_2345_6789);
        wait_idle(1'b1, t);
        check("slv40_rx", g_slv[1].srx, 40'hDE_ADBE_EF01);
        check("done40_count", 40'(done40_n), 40'd2);
        check("q40_drained", 40'(exp40.size()), 40'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 master that sends one fixed-length frame per request and captures the response shifted back on MISO. It drives the smart-home SPI bus from the FPGA side toward our oversampled SPI slave peripherals, such as the humidity/sensor link. Frames are MSB-first with active-low SSEL. A start/busy/done handshake lets a control FSM load `tx_data` and collect `rx_data`.

## Interface
- `FRAME_BITS`, 40: bits per frame (≥1).
- `CLK_DIV`, 8: `clk` cycles per SCK half-period. Must be ≥8 so a slave that oversamples with a 3-stage synchronizer has time to see each edge and update MISO.
- `CS_SETUP`, 8: cycles SSEL is low before the first SCK rise. The same count sets the minimum SSEL-high gap after a frame.
- `CS_HOLD`, 8: cycles SSEL stays low after the last SCK fall.
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a frame. Sampled only in IDLE.
- `tx_data`  in  FRAME_BITS: frame to send. Latched on the accepted `start`.
- `rx_data`  out  FRAME_BITS: last received frame. Updated when `done` pulses.
- `busy`  out  1: high from the cycle after `start` is accepted until the return to IDLE.
- `done`  out  1: one-cycle pulse when the frame completes.
- `SCK`  out  1: SPI clock. Idles low.
- `MOSI`  out  1: master data out.
- `MISO`  in  1: slave data in. Asynchronous.
- `SSEL`  out  1: slave select, active low.

## Operation
- All outputs are registered.
- MISO passes through a 2-flop synchronizer (`miso_s`) before use.
- IDLE:
  - Outputs: SSEL=1, SCK=0, MOSI=0, busy=0.
  - On `start`=1: tx shift reg ← `tx_data`, bitcnt ← 0, go to SETUP.
- SETUP:
  - Outputs: SSEL=0, SCK=0, MOSI = tx shift reg MSB.
  - Lasts CS_SETUP cycles, then go to HIGH.
- HIGH:
  - SCK=1 for CLK_DIV cycles.
  - In the first HIGH cycle, rx shift reg ← {rx[FRAME_BITS-2:0], `miso_s`}.
  - On leaving HIGH, bitcnt++.
- LOW:
  - SCK=0 for CLK_DIV cycles.
  - In the first LOW cycle, tx shift reg shifts left by 1, so MOSI shows the next bit.
  - On leaving LOW: go to HOLD if bitcnt==FRAME_BITS, else to HIGH.
  - MOSI after the final shift is don't-care; the reference model drives 0.
- HOLD:
  - SSEL=0, SCK=0 for CS_HOLD cycles, then go to GAP.
  - On that transition, `rx_data` ← rx shift reg and `done`=1 for one cycle.
- GAP:
  - SSEL=1, busy=1 for CS_SETUP cycles, then go to IDLE.
  - This guarantees the slave sees a distinct SSEL falling edge on the next frame.
- `start` is ignored while busy, including during GAP. It is not queued.
- Exactly FRAME_BITS rising and FRAME_BITS falling SCK edges occur per frame.
- The master samples MISO on the SCK rise; the slave shifts MISO on the SCK fall.
- Counters are sized `$clog2` of their maximum count plus 1. Division counters restart at 0 on every state entry.

## Timing
- Reset values: SCK=0, MOSI=0, SSEL=1, busy=0, done=0, rx_data=0. State = IDLE.
- `rst` mid-frame aborts at the next edge:
  - SSEL rises and SCK goes low immediately.
  - `done` is not pulsed and `rx_data` is cleared.
- Timeline for `start` accepted at edge k:
  - SSEL=0 and busy=1 from cycle k+1.
  - First SCK rise at cycle k+1+CS_SETUP.
  - Last SCK fall ends at k+CS_SETUP+2·CLK_DIV·FRAME_BITS.
  - SSEL=1 and `done`=1 at k+1+CS_SETUP+2·CLK_DIV·FRAME_BITS+CS_HOLD.
  - busy=0 CS_SETUP cycles after that.
- Worked example (FRAME_BITS=8, others at defaults): SSEL low k+1..k+144, SCK first high k+9, `done` at k+145, busy low at k+153.
- The earliest next accepted `start` is the cycle busy=0. It produces SSEL low one cycle later.
- MISO capture latency: a slave MISO update within CLK_DIV−3 cycles of an SCK fall is captured correctly.

## Test plan
- Basic frame, FRAME_BITS=8, `tx_data`=0xA5, slave model returns 0x3C:
  - MOSI observed at SCK rises is 1,0,1,0,0,1,0,1.
  - `rx_data`=0x3C when `done`=1.
  - `done` at k+145, busy falls at k+153.
- Loopback with MISO tied to MOSI, FRAME_BITS=40, `tx_data`=0x12_3456_789A → `rx_data`=0x12_3456_789A.
  - Exactly 40 SCK rises, with SSEL low throughout.
- `start` asserted again during SETUP, HIGH, and GAP of an active frame → ignored.
  - One `done` only, no SCK glitch.
  - A new `start` in the cycle busy=0 → SSEL low at the next cycle.
- `rst` pulsed mid-frame after bit 3 → next cycle SSEL=1, SCK=0, busy=0, `rx_data`=0, no `done`.
  - A following frame with 0xFF→0x81 completes correctly.
- Against the oversampling slave model (3-flop SCK/SSEL sync, MISO shifts on the SCK fall), CLK_DIV=8, 40-bit data 0xDE_AD_BE_EF_01:
  - The slave receives `tx_data` intact.
  - The master `rx_data` equals the slave's loaded word.
- All-zeros and all-ones frames (0x00, 0xFF with FRAME_BITS=8) → MOSI constant over SCK-high phases, `rx_data` matches.
